fp_align_add: RTL and testbench

- Front half of the single-precision FP adder: field masking, exponent alignment and mantissa add/subtract in one registered block.
- Takes two IEEE-754 binary32 operands and produces an un-normalized sign/exponent/mantissa with guard/round/sticky bits.
- Output feeds the downstream normalize stage, which produces the final packed sum.

---
 rtl/fp_pkg.sv | 26 ++
 rtl/fp_align_shift.sv | 35 +++
 rtl/fp_align_add.sv | 145 ++++++++++++++
 tb/tb_fp_align_add.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared types and constants for the binary32 align/add front end.
//   fp32_t   : packed view of an IEEE-754 binary32 word {sign, exp, frac}
//   eff_exp  : effective exponent (denormals behave as exponent 1)
// -----------------------------------------------------------------------------
package fp_pkg;

    localparam int             EXP_W     = 8;
    localparam int             FRAC_W    = 23;
    localparam int             SIG_W     = 24;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam int             SHIFT_SAT = 27;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    // Denormals share the scale of the smallest normal exponent.
    function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
        return (e == '0) ? EXP_W'(1) : e;
    endfunction

endpackage

// File: rtl/fp_align_shift.sv
// -----------------------------------------------------------------------------
// fp_align_shift
// Combinational right shift of a 24-bit significand into a 27-bit
// {m, guard, round, sticky} field. Every bit shifted past the round
// position is ORed into the sticky LSB. Shift distances of 27 or more
// saturate: the field becomes zero apart from sticky = |m_i.
//   m_i       : significand of the smaller operand
//   d_i       : exponent difference (shift distance)
//   aligned_o : shifted significand with guard/round/sticky appended
// -----------------------------------------------------------------------------
module fp_align_shift
    import fp_pkg::*;
(
    input  logic [SIG_W-1:0]     m_i,
    input  logic [EXP_W-1:0]     d_i,
    output logic [SHIFT_SAT-1:0] aligned_o
);

    logic [4:0]           d_sat;
    logic [SHIFT_SAT-1:0] field;
    logic [SHIFT_SAT-1:0] shifted;
    logic [SHIFT_SAT-1:0] lost_bits;

    always_comb begin
        // NOTE: every signal gets a value on every path through this block,
        // so no latch is inferred.
        d_sat     = (d_i >= EXP_W'(SHIFT_SAT)) ? 5'(SHIFT_SAT) : d_i[4:0];
        field     = {m_i, 3'b000};
        shifted   = field >> d_sat;
        // Left-shifting by the complement keeps exactly the bits that fell off.
        lost_bits = field << (5'(SHIFT_SAT) - d_sat);
        aligned_o = {shifted[SHIFT_SAT-1:1], shifted[0] | (|lost_bits)};
    end

endmodule

// File: rtl/fp_align_add.sv
// -----------------------------------------------------------------------------
// fp_align_add
// Front half of a binary32 adder: field decode, exponent alignment and
// significand add/subtract, registered once. The result is un-normalized;
// the downstream normalize stage does the rest.
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid, a, b    : operand strobe and binary32 operands
//   out_valid         : in_valid delayed by one cycle
//   sign_o, exp_o     : result sign, larger operand's effective exponent
//   mant_o, grs_o     : {carry, hidden, frac} magnitude and guard/round/sticky
//   zero_o            : magnitude exactly zero
//   nan_o, inf_o      : special results (only with FP_SPECIAL_EN defined)
// Build option: define FP_SPECIAL_EN to decode exponent 255 as Inf/NaN.
// LATENCY is fixed at 1.
// -----------------------------------------------------------------------------
module fp_align_add
    import fp_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [31:0]       a,
    input  logic [31:0]       b,
    output logic              out_valid,
    output logic              sign_o,
    output logic [EXP_W-1:0]  exp_o,
    output logic [24:0]       mant_o,
    output logic [2:0]        grs_o,
    output logic              zero_o,
    output logic              nan_o,
    output logic              inf_o
);

    fp32_t                fa, fb;
    logic [EXP_W-1:0]     ea, eb, e_l, e_s;
    logic [SIG_W-1:0]     ma, mb, m_l, m_s;
    logic                 s_l, s_s, a_is_l;
    logic [SHIFT_SAT-1:0] aligned;
    logic [27:0]          sum;

    logic                 valid_q;
    logic                 sign_d, sign_q, zero_d, zero_q, nan_d, nan_q, inf_d, inf_q;
    logic [EXP_W-1:0]     exp_d, exp_q;
    logic [24:0]          mant_d, mant_q;
    logic [2:0]           grs_d, grs_q;

    assign fa = fp32_t'(a);
    assign fb = fp32_t'(b);
    assign ea = eff_exp(fa.exp);
    assign eb = eff_exp(fb.exp);
    assign ma = {fa.exp != '0, fa.frac};
    assign mb = {fb.exp != '0, fb.frac};

    // Magnitude order by {exponent, significand}; ties keep A as the larger.
    assign a_is_l = {ea, ma} >= {eb, mb};
    assign e_l    = a_is_l ? ea : eb;
    assign e_s    = a_is_l ? eb : ea;
    assign m_l    = a_is_l ? ma : mb;
    assign m_s    = a_is_l ? mb : ma;
    assign s_l    = a_is_l ? fa.sign : fb.sign;
    assign s_s    = a_is_l ? fb.sign : fa.sign;

    fp_align_shift u_shift (
        .m_i       (m_s),
        .d_i       (e_l - e_s),
        .aligned_o (aligned)
    );

    // L >= S in magnitude, so the subtraction never goes negative.
    assign sum = (s_l == s_s) ? ({1'b0, m_l, 3'b000} + {1'b0, aligned})
                              : ({1'b0, m_l, 3'b000} - {1'b0, aligned});

    always_comb begin
        exp_d  = e_l;
        mant_d = sum[27:3];
        grs_d  = sum[2:0];
        zero_d = (sum == '0);
        // Exact cancellation gives +0; like-signed zeros keep their sign.
        sign_d = (zero_d && (s_l != s_s)) ? 1'b0 : s_l;
        nan_d  = 1'b0;
        inf_d  = 1'b0;
`ifdef FP_SPECIAL_EN
        begin
            logic a_inf, b_inf, a_nan, b_nan;
            a_inf = (fa.exp == EXP_MAX) && (fa.frac == '0);
            b_inf = (fb.exp == EXP_MAX) && (fb.frac == '0);
            a_nan = (fa.exp == EXP_MAX) && (fa.frac != '0);
            b_nan = (fb.exp == EXP_MAX) && (fb.frac != '0);
            if (a_nan || b_nan || (a_inf && b_inf && (fa.sign != fb.sign))) begin
                nan_d  = 1'b1;
                exp_d  = EXP_MAX;
                mant_d = 25'h0C00000;
                grs_d  = 3'b000;
                zero_d = 1'b0;
                sign_d = 1'b0;
            end else if (a_inf || b_inf) begin
                inf_d  = 1'b1;
                exp_d  = EXP_MAX;
                mant_d = 25'h0800000;
                grs_d  = 3'b000;
                zero_d = 1'b0;
                sign_d = a_inf ? fa.sign : fb.sign;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            mant_q  <= '0;
            grs_q   <= '0;
            zero_q  <= 1'b0;
            nan_q   <= 1'b0;
            inf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            valid_q <= in_valid;
            if (in_valid) begin
                sign_q <= sign_d;
                exp_q  <= exp_d;
                mant_q <= mant_d;
                grs_q  <= grs_d;
                zero_q <= zero_d;
                nan_q  <= nan_d;
                inf_q  <= inf_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign sign_o    = sign_q;
    assign exp_o     = exp_q;
    assign mant_o    = mant_q;
    assign grs_o     = grs_q;
    assign zero_o    = zero_q;
    assign nan_o     = nan_q;
    assign inf_o     = inf_q;

endmodule

// File: tb/tb_fp_align_add.sv
// -----------------------------------------------------------------------------
// tb_fp_align_add
// Directed vectors with hand-computed expected results for fp_align_add.
// Special-value vectors are compiled only when FP_SPECIAL_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fp_align_add;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        out_valid, sign_o, zero_o, nan_o, inf_o;
    logic [7:0]  exp_o;
    logic [24:0] mant_o;
    logic [2:0]  grs_o;

    int n_checks = 0;
    int n_pass   = 0;

    fp_align_add #(.LATENCY(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .sign_o    (sign_o),
        .exp_o     (exp_o),
        .mant_o    (mant_o),
        .grs_o     (grs_o),
        .zero_o    (zero_o),
        .nan_o     (nan_o),
        .inf_o     (inf_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Present one operand pair for one cycle and sample just after the edge.
    task automatic apply(input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic s, input logic [7:0] e,
                              input logic [24:0] m, input logic [2:0] g, input logic z);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".sign"},  32'(sign_o),    32'(s));
        check({tag, ".exp"},   32'(exp_o),     32'(e));
        check({tag, ".mant"},  32'(mant_o),    32'(m));
        check({tag, ".grs"},   32'(grs_o),     32'(g));
        check({tag, ".zero"},  32'(zero_o),    32'(z));
    endtask

    initial begin
        #1;
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.mant",  32'(mant_o),    32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // -1.245 + 2.753: B larger, d=1, subtract.
        apply(32'hBF9F5C29, 32'h40303127);
        expect_out("sub_d1", 1'b0, 8'h80, 25'h0608312, 3'b100, 1'b0);
        check("sub_d1.nan", 32'(nan_o), 32'd0);
        check("sub_d1.inf", 32'(inf_o), 32'd0);

        // Hold: with in_valid low the data stays, out_valid drops.
        @(negedge clk);
        a = 32'h3F800000;
        b = 32'h3F800000;
        @(posedge clk);
        #1;
        check("hold.valid", 32'(out_valid), 32'd0);
        check("hold.mant",  32'(mant_o),    32'h0608312);
        check("hold.exp",   32'(exp_o),     32'h80);

        // 1.0 + 1.0: carry out.
        apply(32'h3F800000, 32'h3F800000);
        expect_out("one_one", 1'b0, 8'h7F, 25'h1000000, 3'b000, 1'b0);

        // 1.0 + -1.0: exact cancellation gives +0.
        apply(32'h3F800000, 32'hBF800000);
        expect_out("cancel", 1'b0, 8'h7F, 25'h0000000, 3'b000, 1'b1);

        // -1.0 + 1.0: tie, L=A is negative, still +0.
        apply(32'hBF800000, 32'h3F800000);
        expect_out("cancel_neg", 1'b0, 8'h7F, 25'h0000000, 3'b000, 1'b1);

        // -0 + -0 keeps the negative sign.
        apply(32'h80000000, 32'h80000000);
        expect_out("negzero", 1'b1, 8'h01, 25'h0000000, 3'b000, 1'b1);

        // d=30 saturated shift: only sticky survives.
        apply(32'h3F800000, 32'h30800000);
        expect_out("d30_add", 1'b0, 8'h7F, 25'h0800000, 3'b001, 1'b0);

        // d=30 subtract: borrow through the sticky bit.
        apply(32'h3F800000, 32'hB0800000);
        expect_out("d30_sub", 1'b0, 8'h7F, 25'h07FFFFF, 3'b111, 1'b0);

        // d=27 boundary (saturation threshold).
        apply(32'h3F800000, 32'h32000000);
        expect_out("d27", 1'b0, 8'h7F, 25'h0800000, 3'b001, 1'b0);

        // d=25: hidden bit lands in round position.
        apply(32'h3F800000, 32'h33000000);
        expect_out("d25", 1'b0, 8'h7F, 25'h0800000, 3'b010, 1'b0);

        // Smaller operand as A, negative larger B: sign from B.
        apply(32'h3F800000, 32'hC0000000);
        expect_out("neg_l", 1'b1, 8'h80, 25'h0400000, 3'b000, 1'b0);

        // Denormal + denormal: effective exponent 1, no hidden bit.
        apply(32'h00000001, 32'h00000001);
        expect_out("denorm", 1'b0, 8'h01, 25'h0000002, 3'b000, 1'b0);

`ifdef FP_SPECIAL_EN
        apply(32'h7F800000, 32'h3F800000);
        check("inf.inf",  32'(inf_o),  32'd1);
        check("inf.nan",  32'(nan_o),  32'd0);
        check("inf.exp",  32'(exp_o),  32'hFF);
        check("inf.mant", 32'(mant_o), 32'h0800000);
        check("inf.sign", 32'(sign_o), 32'd0);

        apply(32'h3F800000, 32'hFF800000);
        check("ninf.inf",  32'(inf_o),  32'd1);
        check("ninf.sign", 32'(sign_o), 32'd1);

        apply(32'h7F800000, 32'hFF800000);
        check("nan.nan",  32'(nan_o),  32'd1);
        check("nan.inf",  32'(inf_o),  32'd0);
        check("nan.exp",  32'(exp_o),  32'hFF);
        check("nan.mant", 32'(mant_o), 32'h0C00000);
        check("nan.sign", 32'(sign_o), 32'd0);

        apply(32'h7FC00000, 32'h3F800000);
        check("qnan.nan", 32'(nan_o), 32'd1);
`else
        // Exponent 255 is an ordinary number here: d=128 saturates to sticky.
        apply(32'h7F800000, 32'h3F800000);
        expect_out("e255", 1'b0, 8'hFF, 25'h0800000, 3'b001, 1'b0);
        check("e255.nan", 32'(nan_o), 32'd0);
        check("e255.inf", 32'(inf_o), 32'd0);
`endif

        // Asynchronous reset in mid-cycle with valid operands present.
        @(negedge clk);
        a        = 32'h3F800000;
        b        = 32'h3F800000;
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.valid", 32'(out_valid), 32'd0);
        check("arst.mant",  32'(mant_o),    32'd0);
        check("arst.exp",   32'(exp_o),     32'd0);
        check("arst.sign",  32'(sign_o),    32'd0);
        check("arst.zero",  32'(zero_o),    32'd0);
        check("arst.flags", 32'({nan_o, inf_o, grs_o}), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst.valid", 32'(out_valid), 32'd0);
        check("post_rst.mant",  32'(mant_o),    32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
